// File: rtl/rede_out_argmax.sv
// Collects one signed result per output channel, then scans for the maximum and
// presents {index, score} on a valid/ready handshake. Ties resolve to the lower index.
module rede_out_argmax #(
  parameter int NOUT  = 4,
  parameter int NBITS = 28,
  parameter int CNTW  = 16,
  localparam int IW   = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] io_out,
  input  logic [NOUT-1:0]  out_en,
  output logic [IW-1:0]    res_idx,
  output logic [NBITS-1:0] res_score,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNTW-1:0]  frame_cnt,
  output logic             err_multi,
  output logic             err_overrun
);

  typedef enum logic [1:0] {COLLECT, SCAN, VALID} state_t;

  state_t                  state;
  logic signed [NBITS-1:0] slot [NOUT];
  logic [NOUT-1:0]         filled;
  logic [IW-1:0]           scan_i;
  logic signed [NBITS-1:0] best;
  logic [IW-1:0]           bidx;
  logic signed [NBITS-1:0] nxt_best;
  logic [IW-1:0]           nxt_bidx;
  logic                    any_en;
  logic                    one_hot;

  assign any_en  = |out_en;
  assign one_hot = any_en && ((out_en & (out_en - NOUT'(1))) == '0);

  // Running maximum including the current scan position, so the final
  // comparison lands in res_* on the same edge that enters VALID.
  always_comb begin
    nxt_best = best;
    nxt_bidx = bidx;
    if (scan_i == '0) begin
      nxt_best = slot[0];
      nxt_bidx = '0;
    end else if (slot[scan_i] > best) begin
      nxt_best = slot[scan_i];
      nxt_bidx = scan_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      filled      <= '0;
      for (int k = 0; k < NOUT; k++) slot[k] <= '0;
      scan_i      <= '0;
      best        <= '0;
      bidx        <= '0;
      res_idx     <= '0;
      res_score   <= '0;
      res_valid   <= 1'b0;
      frame_cnt   <= '0;
      err_multi   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (one_hot) begin
            for (int k = 0; k < NOUT; k++)
              if (out_en[k]) slot[k] <= io_out;
            filled <= filled | out_en;
          end else if (any_en) begin
            err_multi <= 1'b1;
          end
          if (&filled) begin
            state  <= SCAN;
            scan_i <= '0;
          end
        end
        SCAN: begin
          if (any_en) err_overrun <= 1'b1;
          best <= nxt_best;
          bidx <= nxt_bidx;
          if (scan_i == IW'(NOUT - 1)) begin
            state     <= VALID;
            filled    <= '0;
            res_idx   <= nxt_bidx;
            res_score <= nxt_best;
            res_valid <= 1'b1;
          end else begin
            scan_i <= scan_i + IW'(1);
          end
        end
        VALID: begin
          if (any_en) err_overrun <= 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            frame_cnt <= frame_cnt + CNTW'(1);
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_rede_out_argmax.sv
// Bench for rede_out_argmax: fixed frame table, hand-written corner sequences,
// and random frames checked against an argmax model over the latest slot values.
module tb_rede_out_argmax;

  localparam int NOUT = 4;
  localparam int NBITS = 28;
  localparam int CNTW = 16;
  localparam int MINV = -134217728;
  localparam int MAXV = 134217727;

  logic             clk = 1'b0;
  logic             rst;
  logic [NBITS-1:0] io_out;
  logic [NOUT-1:0]  out_en;
  logic [1:0]       res_idx;
  logic [NBITS-1:0] res_score;
  logic             res_valid;
  logic             res_ready;
  logic [CNTW-1:0]  frame_cnt;
  logic             err_multi;
  logic             err_overrun;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  int mv [NOUT];

  typedef struct {
    int v [NOUT];
    int eidx;
    int escore;
  } vec_t;
  vec_t tbl [4];

  rede_out_argmax #(.NOUT(NOUT), .NBITS(NBITS), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .io_out(io_out), .out_en(out_en),
    .res_idx(res_idx), .res_score(res_score), .res_valid(res_valid),
    .res_ready(res_ready), .frame_cnt(frame_cnt),
    .err_multi(err_multi), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input int v);
    out_en = NOUT'(1) << k;
    io_out = NBITS'(v);
    mv[k]  = v;
    tick();
    out_en = '0;
  endtask

  function automatic int model_idx();
    int b = 0;
    for (int i = 1; i < NOUT; i++)
      if (mv[i] > mv[b]) b = i;
    return b;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  // Called straight after the write that completes a frame; res_ready already 1.
  task automatic finish_frame(input string nm, input int eidx, input int escore);
    int n;
    wait_valid(n);
    chk({nm, "_latency"}, n, 5);
    chk({nm, "_idx"}, res_idx, eidx);
    chk({nm, "_score"}, $signed(res_score), escore);
    tick();
    exp_cnt++;
    chk({nm, "_valid_drop"}, res_valid, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, exp_cnt % (1 << CNTW));
  endtask

  initial begin
    int n, k, order [NOUT];
    bit done [NOUT];
    rst = 1'b1; io_out = '0; out_en = '0; res_ready = 1'b1;
    tbl[0].v = '{5, -3, 17, 2};           tbl[0].eidx = 2; tbl[0].escore = 17;
    tbl[1].v = '{MINV, MINV, MINV, MINV}; tbl[1].eidx = 0; tbl[1].escore = MINV;
    tbl[2].v = '{7, 7, 3, 7};             tbl[2].eidx = 0; tbl[2].escore = 7;
    tbl[3].v = '{-1, -5, -1, MAXV};       tbl[3].eidx = 3; tbl[3].escore = MAXV;

    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", res_valid, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_score", res_score, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_multi", err_multi, 0);
    chk("rst_overrun", err_overrun, 0);

    for (int t = 0; t < 4; t++) begin
      for (int s = 0; s < NOUT; s++) wr(s, tbl[t].v[s]);
      finish_frame($sformatf("tbl%0d", t), tbl[t].eidx, tbl[t].escore);
    end

    // Overwrite: latest value of slot 1 wins
    wr(1, 9); wr(1, 1); wr(0, 0); wr(2, 0); wr(3, 0);
    finish_frame("overwrite", 1, 1);
    chk("overwrite_multi", err_multi, 0);
    chk("overwrite_overrun", err_overrun, 0);

    // Multi-hot strobe writes nothing and flags err_multi
    wr(0, 3); wr(1, 4);
    out_en = 4'b0101; io_out = NBITS'(100);
    tick();
    out_en = '0;
    chk("multi_flag", err_multi, 1);
    wr(2, -2); wr(3, 1);
    finish_frame("multi_frame", 1, 4);
    chk("multi_sticky", err_multi, 1);

    // Stall in VALID, write arrives and is dropped
    res_ready = 1'b0;
    wr(0, 40); wr(1, 12); wr(2, 40); wr(3, -7);
    wait_valid(n);
    chk("stall_latency", n, 5);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        out_en = 4'b0001; io_out = NBITS'(999);
      end
      tick();
      out_en = '0;
      chk($sformatf("stall_valid%0d", c), res_valid, 1);
      chk($sformatf("stall_idx%0d", c), res_idx, 0);
      chk($sformatf("stall_score%0d", c), $signed(res_score), 40);
    end
    chk("overrun_flag", err_overrun, 1);
    res_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("stall_release", res_valid, 0);
    chk("stall_cnt", frame_cnt, exp_cnt);
    // Slot 0 must not have taken 999 while VALID; 500 on slot 1 must win
    wr(1, 500); wr(2, 1); wr(3, 1); wr(0, 2);
    finish_frame("post_overrun", 1, 500);

    // Random frames: random write order with overwrites and idle gaps
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NOUT; i++) done[i] = 0;
      n = 0;
      while (n < NOUT) begin
        k = $urandom_range(NOUT - 1);
        if (!done[k] && n == NOUT - 1) begin
          done[k] = 1; n++;
        end else if (!done[k]) begin
          done[k] = 1; n++;
        end else if (n == NOUT - 1) begin
          continue;
        end
        if ($urandom_range(3) == 0) tick();
        if ($urandom_range(2) == 0) wr(k, $urandom_range(4) - 2);
        else wr(k, int'($urandom) >>> 4);
      end
      finish_frame($sformatf("rnd%0d", f), model_idx(), mv[model_idx()]);
    end

    // Reset during SCAN cycle 2 discards the frame
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_idx", res_idx, 0);
    chk("mid_rst_score", res_score, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_multi", err_multi, 0);
    chk("mid_rst_overrun", err_overrun, 0);
    n = 0;
    for (int c = 0; c < 8; c++) if (res_valid) n++; else tick();
    chk("mid_rst_no_result", res_valid, 0);
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 50);
    finish_frame("after_rst", 3, 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
